normalize_round_seq: RTL and testbench

//  Reverse of the alignment stage: takes the accumulated two's-complement aligned sum and the shared max exponent.

---
 rtl/normalize_round_seq.sv | 182 ++++++++++++++++++
 tb/tb_normalize_round_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/normalize_round_seq.sv
// normalize_round_seq
//   Normalizes an accumulated two's-complement aligned sum back to the packed
//   sign / exponent / 3-bit mantissa result format ({leading one, f1, f0}).
//   Rounding is round-to-nearest-even. The left shift runs one bit per cycle.
//   Overflow saturates the result and raises o_ovf. Underflow flushes the
//   result to zero and raises o_unf.
//
// Ports
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_valid      : i_sum / i_max_exp valid
//   o_ready      : block can accept (IDLE only)
//   i_sum        : W-bit two's-complement aligned sum
//   i_max_exp    : unsigned exponent carried by bit LD_POS of i_sum
//   o_valid      : result valid, held until accepted
//   i_ready      : downstream accepts result
//   o_sign, o_exp, o_mant, o_ovf, o_unf : result fields and flags
//   dbg_state    : current FSM state (IDLE=0 ABS=1 SHIFT=2 ROUND=3 OUT=4)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The sender holds its data stable while valid=1 and ready=0.
// Here o_ready is high only in IDLE. o_valid is high only in OUT. The two
// phases never overlap, so only one operation is in flight.
module normalize_round_seq #(
  parameter int W      = 15,
  parameter int LD_POS = 13
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_sum,
  input  logic [5:0]   i_max_exp,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_sign,
  output logic [5:0]   o_exp,
  output logic [2:0]   o_mant,
  output logic         o_ovf,
  output logic         o_unf,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ABS   = 3'd1,
    S_SHIFT = 3'd2,
    S_ROUND = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  localparam int CW = $clog2(W + 1);
  localparam logic signed [7:0] OFFS = 8'(W - 1 - LD_POS);
  localparam logic [W-1:0] ONE = W'(1);

  state_t state, state_nx;

  logic [W-1:0]  sum_q;
  logic [5:0]    exp_q;
  logic [W-1:0]  mag_q;
  logic [CW-1:0] c_q;

  // Magnitude of the latched sum. The most negative input wraps to 2^(W-1),
  // which is still the correct unsigned magnitude.
  logic [W-1:0] mag_abs;
  logic [W-1:0] mag_shl;
  assign mag_abs = sum_q[W-1] ? ((~sum_q) + ONE) : sum_q;
  assign mag_shl = mag_q << 1;

  // Rounding / exponent path, evaluated from the normalized magnitude in ROUND.
  logic [2:0]        keep;
  logic              guard, sticky, round_up, carry;
  logic [3:0]        keep_inc;
  logic [2:0]        mant_r;
  logic signed [7:0] e_base, e_fin;

  always_comb begin
    keep     = mag_q[W-1 -: 3];
    guard    = mag_q[W-4];
    sticky   = |mag_q[W-5:0];
    round_up = guard & (sticky | keep[0]);
    keep_inc = {1'b0, keep} + 4'd1;
    carry    = round_up & keep_inc[3];
    if (carry)         mant_r = 3'b100;
    else if (round_up) mant_r = keep_inc[2:0];
    else               mant_r = keep;
    // 8-bit signed, so the full range of max_exp, offset and shift count never wraps.
    e_base = $signed({2'b00, exp_q}) + OFFS - $signed(8'(c_q));
    e_fin  = e_base + (carry ? 8'sd1 : 8'sd0);
  end

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  // FSM: next state
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (i_valid) state_nx = S_ABS;
      S_ABS: begin
        if (mag_abs == '0)    state_nx = S_OUT;
        else if (mag_abs[W-1]) state_nx = S_ROUND;
        else                   state_nx = S_SHIFT;
      end
      S_SHIFT: if (mag_shl[W-1]) state_nx = S_ROUND;
      S_ROUND: state_nx = S_OUT;
      S_OUT:   if (i_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_ready   = (state == S_IDLE);
    o_valid   = (state == S_OUT);
    dbg_state = state;
  end

  // Datapath and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sum_q  <= '0;
      exp_q  <= '0;
      mag_q  <= '0;
      c_q    <= '0;
      o_sign <= 1'b0;
      o_exp  <= '0;
      o_mant <= '0;
      o_ovf  <= 1'b0;
      o_unf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            sum_q <= i_sum;
            exp_q <= i_max_exp;
          end
        end
        S_ABS: begin
          mag_q <= mag_abs;
          c_q   <= '0;
          if (mag_abs == '0) begin
            o_sign <= 1'b0;
            o_exp  <= '0;
            o_mant <= '0;
            o_ovf  <= 1'b0;
            o_unf  <= 1'b0;
          end else begin
            o_sign <= sum_q[W-1];
          end
        end
        S_SHIFT: begin
          mag_q <= mag_shl;
          c_q   <= c_q + CW'(1);
        end
        S_ROUND: begin
          if (e_fin > 8'sd63) begin
            o_exp  <= 6'd63;
            o_mant <= 3'b111;
            o_ovf  <= 1'b1;
            o_unf  <= 1'b0;
          end else if (e_fin < 8'sd1) begin
            o_sign <= 1'b0;
            o_exp  <= '0;
            o_mant <= '0;
            o_ovf  <= 1'b0;
            o_unf  <= 1'b1;
          end else begin
            o_exp  <= e_fin[5:0];
            o_mant <= mant_r;
            o_ovf  <= 1'b0;
            o_unf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_normalize_round_seq.sv
// Testbench for normalize_round_seq (W=15, LD_POS=13).
// Directed vectors with hand-computed results. The driver pushes the expected
// response and accept cycle into queues. The monitor pops and compares them
// when o_valid rises, and it checks that the outputs stay stable while held.
module tb_normalize_round_seq;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic         o_ready;
  logic [W-1:0] i_sum;
  logic [5:0]   i_max_exp;
  logic         o_valid;
  logic         i_ready;
  logic         o_sign;
  logic [5:0]   o_exp;
  logic [2:0]   o_mant;
  logic         o_ovf;
  logic         o_unf;
  logic [2:0]   dbg_state;

  normalize_round_seq #(.W(W), .LD_POS(13)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_sum(i_sum), .i_max_exp(i_max_exp), .o_valid(o_valid), .i_ready(i_ready),
    .o_sign(o_sign), .o_exp(o_exp), .o_mant(o_mant), .o_ovf(o_ovf),
    .o_unf(o_unf), .dbg_state(dbg_state)
  );

  // Clock / reset / cycle counter
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks = 0;
  int errors = 0;

  // Packed expectation: {sign, exp[5:0], mant[2:0], ovf, unf, latency[7:0]}
  logic [19:0] exp_q[$];
  int          acc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [19:0] mk(input logic s, input logic [5:0] e, input logic [2:0] m,
                                     input logic ov, input logic un, input logic [7:0] lat);
    return {s, e, m, ov, un, lat};
  endfunction

  // Monitor / scoreboard
  logic        prev_valid = 1'b0;
  logic [11:0] held;
  always @(negedge clk) begin
    logic [19:0] e;
    int          a;
    if (o_valid && !prev_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_output", 32'(o_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("sign",    32'(o_sign), 32'(e[19]));
        chk("exp",     32'(o_exp),  32'(e[18:13]));
        chk("mant",    32'(o_mant), 32'(e[12:10]));
        chk("ovf",     32'(o_ovf),  32'(e[9]));
        chk("unf",     32'(o_unf),  32'(e[8]));
        chk("latency", 32'(cyc - a + 1), 32'(e[7:0]));
      end
      chk("ready_low_in_out", 32'(o_ready), 32'(0));
      held = {o_sign, o_exp, o_mant, o_ovf, o_unf};
    end else if (o_valid && prev_valid) begin
      chk("held_stable", 32'({o_sign, o_exp, o_mant, o_ovf, o_unf}), 32'(held));
      chk("ready_low_in_out", 32'(o_ready), 32'(0));
    end
    prev_valid = o_valid;
  end

  // Driver tasks (called on negedge)
  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) chk("ready_timeout", 32'(o_ready), 32'(1));
  endtask

  task automatic issue(input logic [W-1:0] s, input logic [5:0] me);
    wait_ready();
    i_valid   = 1'b1;
    i_sum     = s;
    i_max_exp = me;
    @(negedge clk);
    i_valid   = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] s, input logic [5:0] me, input logic [19:0] ex);
    wait_ready();
    exp_q.push_back(ex);
    acc_q.push_back(cyc + 1);
    issue(s, me);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !o_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; i_valid = 1'b0; i_sum = '0; i_max_exp = '0; i_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ready", 32'(o_ready), 32'(1));
    chk("rst_valid", 32'(o_valid), 32'(0));
    chk("rst_result", 32'({o_sign, o_exp, o_mant, o_ovf, o_unf}), 32'(0));
    chk("rst_state", 32'(dbg_state), 32'(0));

    // Normalization, sign, rounding, zero, overflow, underflow
    send(15'h2000, 6'd10, mk(1'b0, 6'd10, 3'b100, 1'b0, 1'b0, 8'd4));
    send(15'h6000, 6'd10, mk(1'b1, 6'd10, 3'b100, 1'b0, 1'b0, 8'd4));
    send(15'h4000, 6'd10, mk(1'b1, 6'd11, 3'b100, 1'b0, 1'b0, 8'd3));
    send(15'h3C00, 6'd10, mk(1'b0, 6'd11, 3'b100, 1'b0, 1'b0, 8'd4));
    send(15'h2400, 6'd10, mk(1'b0, 6'd10, 3'b100, 1'b0, 1'b0, 8'd4));
    send(15'h2C00, 6'd10, mk(1'b0, 6'd10, 3'b110, 1'b0, 1'b0, 8'd4));
    send(15'h2500, 6'd10, mk(1'b0, 6'd10, 3'b101, 1'b0, 1'b0, 8'd4));
    send(15'h0000, 6'd10, mk(1'b0, 6'd0,  3'b000, 1'b0, 1'b0, 8'd2));
    send(15'h3C00, 6'd63, mk(1'b0, 6'd63, 3'b111, 1'b1, 1'b0, 8'd4));
    send(15'h4400, 6'd63, mk(1'b1, 6'd63, 3'b111, 1'b1, 1'b0, 8'd4));
    send(15'h0001, 6'd5,  mk(1'b0, 6'd0,  3'b000, 1'b0, 1'b1, 8'd17));
    send(15'h4000, 6'd0,  mk(1'b1, 6'd1,  3'b100, 1'b0, 1'b0, 8'd3));
    send(15'h2000, 6'd0,  mk(1'b0, 6'd0,  3'b000, 1'b0, 1'b1, 8'd4));
    drain();

    // Back-pressure: hold i_ready low for 5 cycles in OUT while offering new input
    i_ready = 1'b0;
    send(15'h2C00, 6'd10, mk(1'b0, 6'd10, 3'b110, 1'b0, 1'b0, 8'd4));
    n = 0;
    while (!o_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_seen", 32'(o_valid), 32'(1));
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_sum = 15'h1234; i_max_exp = 6'd20;
      @(negedge clk);
      chk("stall_valid", 32'(o_valid), 32'(1));
      chk("stall_ready", 32'(o_ready), 32'(0));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    chk("release_valid", 32'(o_valid), 32'(0));
    chk("release_ready", 32'(o_ready), 32'(1));
    repeat (25) @(negedge clk);
    drain();

    // Reset in the middle of SHIFT: no result may appear
    issue(15'h0001, 6'd5);
    repeat (4) @(negedge clk);
    chk("mid_shift_state", 32'(dbg_state), 32'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_valid", 32'(o_valid), 32'(0));
    chk("rst_mid_ready", 32'(o_ready), 32'(1));
    chk("rst_mid_result", 32'({o_sign, o_exp, o_mant, o_ovf, o_unf}), 32'(0));
    repeat (25) @(negedge clk);

    // Operation after reset recovery
    send(15'h2000, 6'd10, mk(1'b0, 6'd10, 3'b100, 1'b0, 1'b0, 8'd4));
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
